// File: rtl/fb_draw_scheduler.sv
// fb_draw_scheduler
// Sequences solid-colour rectangle fills from NUM_REQ drawing requesters into
// the back buffer of a double-buffered frame memory. Requesters are served
// round-robin; each granted rectangle is clipped to the visible area and
// walked one pixel per accepted write. The front/back select is owned here
// and only flips during vertical blank, on request.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | arbitrate: pending swap first, then round-robin request
// FILL      | present one pixel write per cycle, advance on wr_ready
// DONE      | one-cycle completion pulse to the granted requester
// SWAP_WAIT | hold off grants until vertical blank, then flip buffers
module fb_draw_scheduler #(
   parameter int X_PIXELS = 640,
   parameter int Y_PIXELS = 480,
   parameter int NUM_REQ  = 2,
   parameter int ADDR_W   = 19
) (
   input  logic                    CLOCK_25,
   input  logic                    RESET_N,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ*10-1:0]   req_x0,
   input  logic [NUM_REQ*10-1:0]   req_x1,
   input  logic [NUM_REQ*10-1:0]   req_y0,
   input  logic [NUM_REQ*10-1:0]   req_y1,
   input  logic [NUM_REQ*24-1:0]   req_color,
   output logic [NUM_REQ-1:0]      gnt,
   output logic [NUM_REQ-1:0]      done,
   input  logic                    swap_req,
   output logic                    swap_ack,
   input  logic [9:0]              vga_y,
   output logic                    front_buf,
   output logic                    wr_en,
   output logic                    wr_buf,
   output logic [ADDR_W-1:0]       wr_addr,
   output logic [23:0]             wr_data,
   input  logic                    wr_ready,
   output logic                    busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [9:0]        X_MAX      = 10'(X_PIXELS - 1);
   localparam logic [9:0]        Y_MAX      = 10'(Y_PIXELS - 1);
   localparam logic [9:0]        Y_BLANK    = 10'(Y_PIXELS);
   localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(X_PIXELS);
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FILL      = 2'd1,
      DONE      = 2'd2,
      SWAP_WAIT = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  gnt_idx;
   logic              swap_pending;

   logic [9:0]        x0_q, x1_q, y1_q;
   logic [9:0]        cx_q, cy_q;
   logic [ADDR_W-1:0] addr_q;
   logic [23:0]       color_q;

   // Unpacked per-requester views of the packed rectangle buses
   logic [9:0]  x0_arr    [NUM_REQ];
   logic [9:0]  x1_arr    [NUM_REQ];
   logic [9:0]  y0_arr    [NUM_REQ];
   logic [9:0]  y1_arr    [NUM_REQ];
   logic [23:0] color_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign x0_arr[i]    = req_x0[i*10 +: 10];
      assign x1_arr[i]    = req_x1[i*10 +: 10];
      assign y0_arr[i]    = req_y0[i*10 +: 10];
      assign y1_arr[i]    = req_y1[i*10 +: 10];
      assign color_arr[i] = req_color[i*24 +: 24];
   end

   logic              arb_found;
   logic [IDX_W-1:0]  arb_idx;
   logic [IDX_W-1:0]  cand_idx;

   // Round-robin search: first active request at or above the pointer, wrapping
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!arb_found && req[cand_idx]) begin
            arb_found = 1'b1;
            arb_idx   = cand_idx;
         end
      end
   end

   logic [9:0]        sel_x0, sel_x1c, sel_y0, sel_y1c;
   logic              sel_empty;
   logic [ADDR_W-1:0] start_addr;

   // Clip the selected rectangle to the visible area and find its first pixel
   always_comb begin
      sel_x0     = x0_arr[arb_idx];
      sel_y0     = y0_arr[arb_idx];
      sel_x1c    = (x1_arr[arb_idx] > X_MAX) ? X_MAX : x1_arr[arb_idx];
      sel_y1c    = (y1_arr[arb_idx] > Y_MAX) ? Y_MAX : y1_arr[arb_idx];
      sel_empty  = (sel_x0 > sel_x1c) || (sel_y0 > sel_y1c);
      start_addr = ADDR_W'(sel_y0) * ROW_STRIDE + ADDR_W'(sel_x0);
   end

   logic grant_load;
   logic pix_accept;
   logic swap_fire;
   logic last_pix;

   assign last_pix = (cx_q == x1_q) && (cy_q == y1_q);

   // State register
   always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and per-cycle control strobes
   always_comb begin
      state_nxt  = state;
      grant_load = 1'b0;
      pix_accept = 1'b0;
      swap_fire  = 1'b0;
      case (state)
         IDLE: begin
            if (swap_pending) begin
               state_nxt = SWAP_WAIT;
            end else if (arb_found) begin
               grant_load = 1'b1;
               state_nxt  = sel_empty ? DONE : FILL;
            end
         end
         FILL: begin
            if (wr_ready) begin
               pix_accept = 1'b1;
               if (last_pix) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         SWAP_WAIT: begin
            if (vga_y >= Y_BLANK) begin
               swap_fire = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Outputs decoded from state; grant stays up through FILL and DONE
   always_comb begin
      gnt = '0;
      done = '0;
      if (state == FILL || state == DONE) begin
         gnt[gnt_idx] = 1'b1;
      end
      if (state == DONE) begin
         done[gnt_idx] = 1'b1;
      end
      wr_en    = (state == FILL);
      busy     = (state != IDLE);
      swap_ack = swap_fire;
      wr_buf   = ~front_buf;
      wr_addr  = addr_q;
      wr_data  = color_q;
   end

   // Rectangle walker: latch on grant, step column/row on each accepted write.
   // The row wrap rewinds by the rectangle width and adds one stride, which
   // avoids a multiplier in the per-pixel path.
   always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
      if (!RESET_N) begin
         gnt_idx <= '0;
         x0_q    <= '0;
         x1_q    <= '0;
         y1_q    <= '0;
         cx_q    <= '0;
         cy_q    <= '0;
         addr_q  <= '0;
         color_q <= '0;
      end else if (grant_load) begin
         gnt_idx <= arb_idx;
         x0_q    <= sel_x0;
         x1_q    <= sel_x1c;
         y1_q    <= sel_y1c;
         cx_q    <= sel_x0;
         cy_q    <= sel_y0;
         addr_q  <= start_addr;
         color_q <= color_arr[arb_idx];
      end else if (pix_accept && !last_pix) begin
         if (cx_q == x1_q) begin
            cx_q   <= x0_q;
            cy_q   <= cy_q + 10'd1;
            addr_q <= addr_q + ROW_STRIDE - ADDR_W'(x1_q - x0_q);
         end else begin
            cx_q   <= cx_q + 10'd1;
            addr_q <= addr_q + 1'b1;
         end
      end
   end

   // Round-robin pointer moves past the requester just completed
   always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
      if (!RESET_N) begin
         rr_ptr <= '0;
      end else if (state == DONE) begin
         rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Swap bookkeeping; a request landing on the swap cycle merges into it
   always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
      if (!RESET_N) begin
         swap_pending <= 1'b0;
         front_buf    <= 1'b0;
      end else begin
         if (swap_fire) begin
            swap_pending <= 1'b0;
            front_buf    <= ~front_buf;
         end else if (swap_req) begin
            swap_pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fb_draw_scheduler.sv
// Directed bench for fb_draw_scheduler: fills, contention, clipping,
// backpressure, buffer swap and reset mid-fill.
module tb_fb_draw_scheduler;

   localparam int NR = 2;

   logic              CLOCK_25 = 1'b0;
   logic              RESET_N  = 1'b0;
   logic [NR-1:0]     req      = '0;
   logic [NR*10-1:0]  req_x0   = '0;
   logic [NR*10-1:0]  req_x1   = '0;
   logic [NR*10-1:0]  req_y0   = '0;
   logic [NR*10-1:0]  req_y1   = '0;
   logic [NR*24-1:0]  req_color = '0;
   logic [NR-1:0]     gnt;
   logic [NR-1:0]     done;
   logic              swap_req = 1'b0;
   logic              swap_ack;
   logic [9:0]        vga_y    = '0;
   logic              front_buf;
   logic              wr_en;
   logic              wr_buf;
   logic [18:0]       wr_addr;
   logic [23:0]       wr_data;
   logic              wr_ready = 1'b1;
   logic              busy;

   fb_draw_scheduler #(
      .X_PIXELS(640), .Y_PIXELS(480), .NUM_REQ(NR), .ADDR_W(19)
   ) dut (
      .CLOCK_25 (CLOCK_25),
      .RESET_N  (RESET_N),
      .req      (req),
      .req_x0   (req_x0),
      .req_x1   (req_x1),
      .req_y0   (req_y0),
      .req_y1   (req_y1),
      .req_color(req_color),
      .gnt      (gnt),
      .done     (done),
      .swap_req (swap_req),
      .swap_ack (swap_ack),
      .vga_y    (vga_y),
      .front_buf(front_buf),
      .wr_en    (wr_en),
      .wr_buf   (wr_buf),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .busy     (busy)
   );

   always #20 CLOCK_25 = ~CLOCK_25;

   int n_checks = 0;
   int n_fail   = 0;
   int ncyc     = 0;

   logic [31:0] acc_addr[$];
   logic [31:0] acc_data[$];
   logic [31:0] acc_buf[$];
   logic [31:0] acc_gnt[$];
   logic [31:0] acc_cyc[$];
   logic [31:0] done_val[$];
   int          wr_en_cnt = 0;
   int          swap_cnt  = 0;
   int          swap_cyc  = 0;
   int          bad_gnt   = 0;

   always @(negedge CLOCK_25) ncyc++;

   // Monitor samples 3 ns after the falling edge, after the stimulus update,
   // so it sees exactly the values the next rising edge will act on.
   always begin
      @(negedge CLOCK_25);
      #3;
      if (wr_en) begin
         wr_en_cnt++;
         if ($countones(gnt) != 1) bad_gnt++;
         if (wr_ready) begin
            acc_addr.push_back(32'(wr_addr));
            acc_data.push_back(32'(wr_data));
            acc_buf.push_back(32'(wr_buf));
            acc_gnt.push_back(32'(gnt));
            acc_cyc.push_back(32'(ncyc));
         end
      end
      if (|done) done_val.push_back(32'(done));
      if (swap_ack) begin
         swap_cnt++;
         swap_cyc = ncyc;
      end
   end

   initial begin
      #4000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge CLOCK_25);
      #2;
   endtask

   task automatic clear_log();
      acc_addr.delete();
      acc_data.delete();
      acc_buf.delete();
      acc_gnt.delete();
      acc_cyc.delete();
      done_val.delete();
      wr_en_cnt = 0;
      swap_cnt  = 0;
      bad_gnt   = 0;
   endtask

   task automatic set_rect(input int i, input int x0, input int y0, input int x1, input int y1,
                           input logic [23:0] c);
      req_x0[i*10 +: 10]    = x0[9:0];
      req_y0[i*10 +: 10]    = y0[9:0];
      req_x1[i*10 +: 10]    = x1[9:0];
      req_y1[i*10 +: 10]    = y1[9:0];
      req_color[i*24 +: 24] = c;
   endtask

   task automatic wait_done(input int budget, output int got_cyc);
      got_cyc = -1;
      for (int k = 0; k < budget; k++) begin
         tick();
         if (|done) begin
            got_cyc = ncyc;
            break;
         end
      end
      if (got_cyc < 0) check_val("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic reset_dut();
      RESET_N = 1'b0;
      tick();
      tick();
      RESET_N = 1'b1;
      tick();
   endtask

   logic [31:0] exp_addr[4];
   logic [31:0] exp_gnt[4];
   logic [31:0] seq[4];
   int t0, dc;
   logic [31:0] gnt_at_done;

   initial begin
      // Reset state
      repeat (3) tick();
      check_val("rst_gnt",   32'(gnt), 32'd0);
      check_val("rst_done",  32'(done), 32'd0);
      check_val("rst_swack", 32'(swap_ack), 32'd0);
      check_val("rst_wr_en", 32'(wr_en), 32'd0);
      check_val("rst_busy",  32'(busy), 32'd0);
      check_val("rst_addr",  32'(wr_addr), 32'd0);
      check_val("rst_data",  32'(wr_data), 32'd0);
      check_val("rst_front", 32'(front_buf), 32'd0);
      RESET_N = 1'b1;
      tick();

      // Basic 2x2 fill
      clear_log();
      set_rect(0, 10, 20, 11, 21, 24'hF1948A);
      wr_ready = 1'b1;
      req = 2'b01;
      t0 = ncyc;
      wait_done(40, dc);
      req = 2'b00;
      tick();
      tick();
      exp_addr = '{32'd12810, 32'd12811, 32'd13450, 32'd13451};
      check_val("fill_wr_en_cycles", 32'(wr_en_cnt), 32'd4);
      check_val("fill_count", 32'(acc_addr.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < acc_addr.size()) begin
            check_val("fill_addr", acc_addr[i], exp_addr[i]);
            check_val("fill_data", acc_data[i], 32'hF1948A);
            check_val("fill_buf",  acc_buf[i], 32'd1);
         end
      end
      check_val("fill_done_latency", 32'(dc - t0), 32'd5);
      if (acc_cyc.size() == 4) check_val("fill_done_after_last", 32'(dc), acc_cyc[3] + 32'd1);
      if (done_val.size() > 0) check_val("fill_done_which", done_val[0], 32'd1);

      // Contention: both requesters, 1-pixel rects, re-raised after done
      reset_dut();
      clear_log();
      set_rect(0, 1, 1, 1, 1, 24'h111111);
      set_rect(1, 2, 2, 2, 2, 24'h222222);
      req = 2'b11;
      for (int g = 0; g < 4; g++) begin
         wait_done(40, dc);
         seq[g] = 32'(done);
         req = req & ~done;
         tick();
         req = (g < 3) ? 2'b11 : 2'b00;
      end
      tick();
      exp_gnt  = '{32'd1, 32'd2, 32'd1, 32'd2};
      exp_addr = '{32'd641, 32'd1282, 32'd641, 32'd1282};
      for (int g = 0; g < 4; g++) check_val("rr_done_order", seq[g], exp_gnt[g]);
      check_val("rr_count", 32'(acc_addr.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < acc_addr.size()) begin
            check_val("rr_addr", acc_addr[i], exp_addr[i]);
            check_val("rr_gnt",  acc_gnt[i], exp_gnt[i]);
         end
      end
      check_val("rr_onehot", 32'(bad_gnt), 32'd0);

      // Clipping at the bottom-right corner
      clear_log();
      set_rect(0, 638, 479, 700, 500, 24'hABCDEF);
      req = 2'b01;
      wait_done(40, dc);
      req = 2'b00;
      tick();
      check_val("clip_count", 32'(acc_addr.size()), 32'd2);
      if (acc_addr.size() >= 2) begin
         check_val("clip_addr0", acc_addr[0], 32'd307198);
         check_val("clip_addr1", acc_addr[1], 32'd307199);
      end

      // Empty rectangle: no writes, done right after arbitration
      clear_log();
      set_rect(0, 5, 5, 4, 9, 24'h00FF00);
      req = 2'b01;
      t0 = ncyc;
      wait_done(40, dc);
      gnt_at_done = 32'(gnt);
      req = 2'b00;
      tick();
      check_val("empty_latency", 32'(dc - t0), 32'd1);
      check_val("empty_writes", 32'(wr_en_cnt), 32'd0);
      check_val("empty_gnt", gnt_at_done, 32'd1);

      // Backpressure on the second pixel
      clear_log();
      set_rect(0, 0, 0, 2, 0, 24'h0055AA);
      wr_ready = 1'b1;
      req = 2'b01;
      tick();
      tick();
      check_val("bp_pre_addr", 32'(wr_addr), 32'd1);
      wr_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check_val("bp_stall_addr", 32'(wr_addr), 32'd1);
         check_val("bp_stall_data", 32'(wr_data), 32'h0055AA);
         check_val("bp_stall_wr_en", 32'(wr_en), 32'd1);
      end
      wr_ready = 1'b1;
      wait_done(40, dc);
      req = 2'b00;
      tick();
      check_val("bp_count", 32'(acc_addr.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < acc_addr.size()) check_val("bp_addr", acc_addr[i], 32'(i));
      end
      check_val("bp_wr_en_cycles", 32'(wr_en_cnt), 32'd8);

      // Buffer swap waits for vertical blank and blocks grants meanwhile
      clear_log();
      vga_y = 10'd100;
      tick();
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      repeat (4) tick();
      check_val("swap_wait_front", 32'(front_buf), 32'd0);
      check_val("swap_wait_busy",  32'(busy), 32'd1);
      check_val("swap_wait_ack",   32'(swap_cnt), 32'd0);
      set_rect(0, 3, 0, 3, 0, 24'h777777);
      req = 2'b01;
      repeat (3) tick();
      check_val("swap_no_grant", 32'(acc_addr.size()), 32'd0);
      check_val("swap_gnt_low",  32'(gnt), 32'd0);
      vga_y = 10'd480;
      wait_done(40, dc);
      req = 2'b00;
      vga_y = 10'd0;
      tick();
      check_val("swap_ack_count", 32'(swap_cnt), 32'd1);
      check_val("swap_front", 32'(front_buf), 32'd1);
      check_val("swap_req_writes", 32'(acc_addr.size()), 32'd1);
      if (acc_addr.size() == 1) begin
         check_val("swap_wr_buf", acc_buf[0], 32'd0);
         check_val("swap_addr", acc_addr[0], 32'd3);
         check_val("swap_order", 32'(acc_cyc[0] > 32'(swap_cyc)), 32'd1);
      end

      // Reset during pixel 2 of a 4-pixel fill
      clear_log();
      set_rect(0, 0, 2, 1, 3, 24'h123456);
      req = 2'b01;
      tick();
      tick();
      check_val("rst_mid_pix2", 32'(wr_addr), 32'd1281);
      RESET_N = 1'b0;
      #1;
      check_val("rstm_wr_en", 32'(wr_en), 32'd0);
      check_val("rstm_gnt",   32'(gnt), 32'd0);
      check_val("rstm_done",  32'(done), 32'd0);
      check_val("rstm_busy",  32'(busy), 32'd0);
      check_val("rstm_addr",  32'(wr_addr), 32'd0);
      check_val("rstm_data",  32'(wr_data), 32'd0);
      check_val("rstm_front", 32'(front_buf), 32'd0);
      tick();
      tick();
      check_val("rstm_no_done", 32'(done_val.size()), 32'd0);
      clear_log();
      RESET_N = 1'b1;
      wait_done(40, dc);
      req = 2'b00;
      tick();
      exp_addr = '{32'd1280, 32'd1281, 32'd1920, 32'd1921};
      check_val("rstm_restart_count", 32'(acc_addr.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < acc_addr.size()) check_val("rstm_restart_addr", acc_addr[i], exp_addr[i]);
      end
      check_val("rstm_done_count", 32'(done_val.size()), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
